tone_generator: RTL
===================

// Module: tone_generator
// PURPOSE
//  Downstream of the music control unit. Turns its 16-bit speaker_divider into the square wave
//  that drives the speaker pin. Tone changes take effect only at whole-period boundaries, so no
//  runt pulses appear. Divider 0 plays a rest. A note_strobe inserts a short silent gap, so
//  repeated notes are heard as separate notes.
// PARAMETERS
//  DIV_WIDTH   16    width of divider input; divider = half-period length in clk cycles
//  GAP_CYCLES  1000  silent cycles inserted per note_strobe; 0 = no gap, phase reset only
//  VOL_WIDTH   4     width of volume input and PWM counter (used only with TONE_GEN_VOLUME_EN)
// PORTS
//  clk          in   1          system clock, single domain
//  rst_n        in   1          synchronous reset, active-low
//  enable       in   1          1 = generate tone; 0 = forced silence
//  divider      in   DIV_WIDTH  half-period in cycles; 0 = rest
//  note_strobe  in   1          1-cycle pulse when control unit loads a new note
//  volume       in   VOL_WIDTH  PWM duty within high half (only if TONE_GEN_VOLUME_EN)
//  speaker      out  1          registered square-wave output
//  period_tick  out  1          1-cycle pulse on every speaker rising edge (start of a period)
//  playing      out  1          1 while state==PLAY
// BEHAVIOUR
//  - Reset (rst_n==0 at posedge clk): state=IDLE, speaker=0, period_tick=0, playing=0,
//    active_div=0, half_cnt=0, gap_cnt=0, phase=LOW. Reset mid-note aborts at once.
//  - State machine IDLE / PLAY / GAP.
//    * Priority per cycle: enable==0 > note_strobe > normal counting.
//  - IDLE: speaker=0.
//    * enable==1 and divider!=0 -> PLAY next cycle, with active_div=divider and
//      half_cnt=divider-1.
//    * In the same transition speaker=1 and period_tick=1. Latency: 1 cycle from divider valid.
//  - PLAY: half_cnt decrements every cycle.
//    * half_cnt==0 in HIGH phase: speaker->0, half_cnt=active_div-1.
//    * half_cnt==0 in LOW phase (period boundary): sample divider.
//      - divider==0 -> IDLE, speaker stays 0.
//      - else active_div=divider, half_cnt=divider-1, speaker->1, period_tick=1.
//    * Divider changes mid-period are ignored until the next boundary.
//    * Period = 2*active_div cycles, duty 50%. divider==1 toggles every cycle.
//  - note_strobe==1 (enable==1), any state:
//    * GAP_CYCLES>0: -> GAP, speaker=0 next cycle, gap_cnt=GAP_CYCLES-1.
//    * GAP_CYCLES==0: phase reset. Treated as IDLE entry: divider!=0 -> PLAY with speaker=1;
//      else IDLE.
//  - GAP: speaker=0 and gap_cnt decrements.
//    * A strobe during GAP reloads gap_cnt (gap restarts).
//    * gap_cnt==0: behave as IDLE entry, using the divider present that cycle.
//  - enable==0: -> IDLE next cycle, speaker=0, counters cleared; the current period is
//    abandoned.
//  - Counters are DIV_WIDTH and $clog2(GAP_CYCLES+1) bits wide; no wrap past zero.
//    Reload happens on the ==0 cycle.
//  - All outputs are registered. No combinational path from inputs to outputs.
// CONFIGURATION
//  TONE_GEN_VOLUME_EN defined:
//    * volume port exists. A free-running VOL_WIDTH-bit pwm_cnt runs from reset (reset value 0).
//    * speaker = tone_high & (pwm_cnt < volume), registered.
//    * volume==0 silences the output; maximum volume leaves 1 low slot per 2^VOL_WIDTH cycles.
//    * period_tick and playing are unaffected by volume.
//  TONE_GEN_VOLUME_EN undefined: no volume port, no pwm_cnt, speaker = tone_high (pure square).
// TESTING
//  1 Reset, enable=1, divider=4 -> speaker 1 on cycle 1, then high 4 / low 4 repeating;
//    period_tick every 8 cycles.
//  2 Divider changes 4->6 at cycle 3 of a high half -> current period stays 8 cycles;
//    next period is 6 high / 6 low.
//  3 Divider 5->0 mid-period -> period completes (5 high / 5 low), then IDLE, speaker 0,
//    playing 0.
//  4 GAP_CYCLES=10, note_strobe while playing divider=3 -> speaker 0 for exactly 10 cycles,
//    then restarts high 3 / low 3. A second strobe at gap cycle 5 -> gap extends to 15 total.
//  5 enable 1->0 mid-high-half -> speaker 0 next cycle. rst_n low mid-gap -> all outputs 0
//    next cycle. divider=1 -> speaker toggles every cycle.
//  6 (TONE_GEN_VOLUME_EN, VOL_WIDTH=4) volume=4, divider=32 -> in each high half, speaker high
//    4 of every 16 cycles; volume=0 -> speaker always 0, period_tick still every 64 cycles.

Source files
------------

// File: rtl/tone_generator.sv
`default_nettype none
// ============================================================================
//  Module      : tone_generator
//  Description : Square-wave speaker driver. Converts a half-period divider
//                into a 50% duty tone; tone changes land on whole-period
//                boundaries, divider 0 is a rest, and note_strobe inserts a
//                silent gap so repeated notes are heard as separate notes.
//                Optional PWM volume control is enabled by defining the
//                macro TONE_GEN_VOLUME_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tone_generator #(
    parameter int DIV_WIDTH  = 16,
    parameter int GAP_CYCLES = 1000
`ifdef TONE_GEN_VOLUME_EN
    ,
    parameter int VOL_WIDTH  = 4
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] divider,
    input  logic                 note_strobe,
`ifdef TONE_GEN_VOLUME_EN
    input  logic [VOL_WIDTH-1:0] volume,
`endif
    output logic                 speaker,
    output logic                 period_tick,
    output logic                 playing
);

    // Gap counter holds GAP_CYCLES-1 down to 0; keep at least one bit so the
    // GAP_CYCLES==0 build still elaborates.
    localparam int c_gap_w = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [c_gap_w-1:0] c_gap_reload =
        c_gap_w'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam logic c_gap_en = (GAP_CYCLES > 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t                state_q,      state_d;
    logic [DIV_WIDTH-1:0]  active_div_q, active_div_d;
    logic [DIV_WIDTH-1:0]  half_cnt_q,   half_cnt_d;
    logic [c_gap_w-1:0]    gap_cnt_q,    gap_cnt_d;
    logic                  phase_q,      phase_d;     // 1 = high half of period
    logic                  tick_q,       tick_d;
    logic                  speaker_q,    speaker_d;
    logic                  playing_q,    playing_d;
    logic                  w_start;                    // take the IDLE-entry path

`ifdef TONE_GEN_VOLUME_EN
    logic [VOL_WIDTH-1:0]  pwm_cnt_q;

    // Free-running PWM slot counter for volume gating.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + VOL_WIDTH'(1);
        end
    end
`endif

    // Next-state logic: enable has top priority, then note_strobe, then counting.
    always_comb begin
        state_d      = state_q;
        active_div_d = active_div_q;
        half_cnt_d   = half_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        phase_d      = phase_q;
        tick_d       = 1'b0;
        w_start      = 1'b0;

        if (!enable) begin
            state_d      = ST_IDLE;
            active_div_d = '0;
            half_cnt_d   = '0;
            gap_cnt_d    = '0;
            phase_d      = 1'b0;
        end else if (note_strobe) begin
            if (c_gap_en) begin
                state_d    = ST_GAP;
                gap_cnt_d  = c_gap_reload;
                half_cnt_d = '0;
                phase_d    = 1'b0;
            end else begin
                // Zero-length gap: only restart the phase.
                w_start = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    w_start = 1'b1;
                end
                ST_PLAY: begin
                    if (half_cnt_q != '0) begin
                        half_cnt_d = half_cnt_q - DIV_WIDTH'(1);
                    end else if (phase_q) begin
                        phase_d    = 1'b0;
                        half_cnt_d = active_div_q - DIV_WIDTH'(1);
                    end else begin
                        // Period boundary: the only point a new divider is taken.
                        w_start = 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q != '0) begin
                        gap_cnt_d = gap_cnt_q - c_gap_w'(1);
                    end else begin
                        w_start = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (w_start) begin
            gap_cnt_d = '0;
            if (divider != '0) begin
                state_d      = ST_PLAY;
                active_div_d = divider;
                half_cnt_d   = divider - DIV_WIDTH'(1);
                phase_d      = 1'b1;
                tick_d       = 1'b1;
            end else begin
                state_d      = ST_IDLE;
                active_div_d = '0;
                half_cnt_d   = '0;
                phase_d      = 1'b0;
            end
        end

        playing_d = (state_d == ST_PLAY);
`ifdef TONE_GEN_VOLUME_EN
        speaker_d = phase_d & (pwm_cnt_q < volume);
`else
        speaker_d = phase_d;
`endif
    end

    // State, counters and all outputs are registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            active_div_q <= '0;
            half_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            phase_q      <= 1'b0;
            tick_q       <= 1'b0;
            speaker_q    <= 1'b0;
            playing_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            active_div_q <= active_div_d;
            half_cnt_q   <= half_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            phase_q      <= phase_d;
            tick_q       <= tick_d;
            speaker_q    <= speaker_d;
            playing_q    <= playing_d;
        end
    end

    assign speaker     = speaker_q;
    assign period_tick = tick_q;
    assign playing     = playing_q;

endmodule
`default_nettype wire
